// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer: state and segment
// encodings, default segment lengths and the per-program segment tables.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN_W = 3'd1,
        ST_RUN_R = 3'd2,
        ST_RUN_S = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEG_NONE = 2'd0,
        SEG_W    = 2'd1,
        SEG_R    = 2'd2,
        SEG_S    = 2'd3
    } seg_t;

    localparam int DEF_SEG_W_LEN = 12;
    localparam int DEF_SEG_R_LEN = 15;
    localparam int DEF_SEG_S_LEN = 6;
    localparam int DEF_BUZZ_LEN  = 8;

    localparam logic [2:0] MODE_MAX = 3'd5;
    localparam int         MAX_SEGS = 3;

    // Segment list of each program; positions past the end return SEG_NONE.
    function automatic seg_t seg_at(input logic [2:0] m, input logic [1:0] idx);
        seg_t s;
        s = SEG_NONE;
        case (m)
            3'd0: case (idx)
                      2'd0:    s = SEG_W;
                      2'd1:    s = SEG_R;
                      2'd2:    s = SEG_S;
                      default: s = SEG_NONE;
                  endcase
            3'd1: if (idx == 2'd0) s = SEG_W;
            3'd2: case (idx)
                      2'd0:    s = SEG_W;
                      2'd1:    s = SEG_R;
                      default: s = SEG_NONE;
                  endcase
            3'd3: if (idx == 2'd0) s = SEG_R;
            3'd4: case (idx)
                      2'd0:    s = SEG_R;
                      2'd1:    s = SEG_S;
                      default: s = SEG_NONE;
                  endcase
            3'd5: if (idx == 2'd0) s = SEG_S;
            default: s = SEG_NONE;
        endcase
        return s;
    endfunction

    // Program total: sum of the segment lengths in the program's list.
    function automatic logic [5:0] mode_total(input logic [2:0] m,
                                              input logic [4:0] lw,
                                              input logic [4:0] lr,
                                              input logic [4:0] ls);
        logic [5:0] sum;
        sum = 6'd0;
        for (int i = 0; i < MAX_SEGS; i++) begin
            case (seg_at(m, i[1:0]))
                SEG_W:   sum = sum + {1'b0, lw};
                SEG_R:   sum = sum + {1'b0, lr};
                SEG_S:   sum = sum + {1'b0, ls};
                default: sum = sum;
            endcase
        end
        return sum;
    endfunction

endpackage

// File: rtl/wash_seq_ctrl_seg_timer.sv
// Loadable segment down-counter. Load wins over counting; counting stops at 0.
module wash_seg_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_en,
    input  logic         hold,
    output logic [W-1:0] cnt,
    output logic         last_tick
);

    // Count register: load, else decrement on an un-held tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (tick_en && !hold && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign last_tick = tick_en & ~hold & (cnt == W'(1));

endmodule

// File: rtl/wash_seq_ctrl.sv
// Washing-machine program sequencer: mode selection, segment sequencing,
// pause/resume, actuator decode and end-of-cycle buzzer.
module wash_seq_ctrl
    import wash_pkg::*;
#(
    parameter int SEG_W_LEN = DEF_SEG_W_LEN,
    parameter int SEG_R_LEN = DEF_SEG_R_LEN,
    parameter int SEG_S_LEN = DEF_SEG_S_LEN,
    parameter int BUZZ_LEN  = DEF_BUZZ_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       start_btn,
    input  logic       power_on,
    input  logic       door_closed,
    output logic [2:0] mode,
    output logic [2:0] state,
    output logic [5:0] t_total,
    output logic [4:0] t_seg,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor_wash,
    output logic       motor_rinse,
    output logic       motor_spin,
    output logic       done,
    output logic       buzz
);

    localparam logic [4:0] LEN_W     = SEG_W_LEN[4:0];
    localparam logic [4:0] LEN_R     = SEG_R_LEN[4:0];
    localparam logic [4:0] LEN_S     = SEG_S_LEN[4:0];
    localparam logic [7:0] BUZZ_INIT = BUZZ_LEN[7:0];
    localparam logic [5:0] RST_TOTAL = mode_total(3'd0, LEN_W, LEN_R, LEN_S);

    function automatic logic [4:0] seg_len(input seg_t s);
        case (s)
            SEG_W:   return LEN_W;
            SEG_R:   return LEN_R;
            SEG_S:   return LEN_S;
            default: return 5'd0;
        endcase
    endfunction

    function automatic state_t seg_state(input seg_t s);
        case (s)
            SEG_W:   return ST_RUN_W;
            SEG_R:   return ST_RUN_R;
            SEG_S:   return ST_RUN_S;
            default: return ST_DONE;
        endcase
    endfunction

    state_t     st, st_nx, resume_st, resume_nx;
    logic [1:0] seg_idx, seg_idx_nx;
    logic [2:0] mode_r, mode_nx, mode_inc;
    logic [5:0] tot_r, tot_nx;
    logic       buzz_r, buzz_nx;
    logic [7:0] bcnt, bcnt_nx;
    logic       tload;
    logic [4:0] tload_val;
    logic       last_tick;
    logic       is_run, run_ok;
    seg_t       first_seg, next_seg;
    logic [4:0] cur_len, elapsed;

    assign is_run    = (st == ST_RUN_W) || (st == ST_RUN_R) || (st == ST_RUN_S);
    assign run_ok    = is_run & power_on & door_closed & ~start_btn;
    assign mode_inc  = (mode_r == MODE_MAX) ? 3'd0 : mode_r + 3'd1;
    assign first_seg = seg_at(mode_r, 2'd0);
    assign next_seg  = seg_at(mode_r, seg_idx + 2'd1);

    wash_seg_timer #(.W(5)) u_seg_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tload),
        .load_val  (tload_val),
        .tick_en   (tick),
        .hold      (~run_ok),
        .cnt       (t_seg),
        .last_tick (last_tick)
    );

    // Control and program registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            resume_st <= ST_IDLE;
            seg_idx   <= 2'd0;
            mode_r    <= 3'd0;
            tot_r     <= RST_TOTAL;
            buzz_r    <= 1'b0;
            bcnt      <= 8'd0;
        end else begin
            st        <= st_nx;
            resume_st <= resume_nx;
            seg_idx   <= seg_idx_nx;
            mode_r    <= mode_nx;
            tot_r     <= tot_nx;
            buzz_r    <= buzz_nx;
            bcnt      <= bcnt_nx;
        end
    end

    // Next-state logic; power loss overrides everything else.
    always_comb begin
        st_nx      = st;
        resume_nx  = resume_st;
        seg_idx_nx = seg_idx;
        mode_nx    = mode_r;
        tot_nx     = tot_r;
        buzz_nx    = buzz_r;
        bcnt_nx    = bcnt;
        tload      = 1'b0;
        tload_val  = 5'd0;
        if (!power_on) begin
            st_nx      = ST_IDLE;
            seg_idx_nx = 2'd0;
            tot_nx     = mode_total(mode_r, LEN_W, LEN_R, LEN_S);
            tload      = 1'b1;
            buzz_nx    = 1'b0;
            bcnt_nx    = 8'd0;
        end else begin
            case (st)
                ST_IDLE, ST_DONE: begin
                    if (mode_btn) begin
                        mode_nx = mode_inc;
                        tot_nx  = mode_total(mode_inc, LEN_W, LEN_R, LEN_S);
                        tload   = 1'b1;
                        st_nx   = ST_IDLE;
                        buzz_nx = 1'b0;
                        bcnt_nx = 8'd0;
                    end else if ((st == ST_IDLE) && start_btn && door_closed) begin
                        seg_idx_nx = 2'd0;
                        st_nx      = seg_state(first_seg);
                        tot_nx     = mode_total(mode_r, LEN_W, LEN_R, LEN_S);
                        tload      = 1'b1;
                        tload_val  = seg_len(first_seg);
                    end else if ((st == ST_DONE) && tick && (bcnt != 8'd0)) begin
                        bcnt_nx = bcnt - 8'd1;
                        buzz_nx = (bcnt == 8'd1) ? 1'b0 : ~buzz_r;
                    end
                end
                ST_RUN_W, ST_RUN_R, ST_RUN_S: begin
                    if (start_btn || !door_closed) begin
                        st_nx     = ST_PAUSE;
                        resume_nx = st;
                    end else if (tick) begin
                        tot_nx = (tot_r != 6'd0) ? tot_r - 6'd1 : 6'd0;
                        if (last_tick) begin
                            tload = 1'b1;
                            if (next_seg == SEG_NONE) begin
                                st_nx     = ST_DONE;
                                tload_val = 5'd0;
                                buzz_nx   = 1'b1;
                                bcnt_nx   = BUZZ_INIT;
                            end else begin
                                seg_idx_nx = seg_idx + 2'd1;
                                st_nx      = seg_state(next_seg);
                                tload_val  = seg_len(next_seg);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_btn && door_closed)
                        st_nx = resume_st;
                end
                default: st_nx = ST_IDLE;
            endcase
        end
    end

    // Actuator decode from elapsed time in the current segment.
    always_comb begin
        valve_in    = 1'b0;
        valve_out   = 1'b0;
        motor_wash  = 1'b0;
        motor_rinse = 1'b0;
        motor_spin  = 1'b0;
        case (st)
            ST_RUN_W: cur_len = LEN_W;
            ST_RUN_R: cur_len = LEN_R;
            ST_RUN_S: cur_len = LEN_S;
            default:  cur_len = 5'd0;
        endcase
        elapsed = cur_len - t_seg;
        case (st)
            ST_RUN_W: begin
                if (elapsed < 5'd3) valve_in = 1'b1;
                else                motor_wash = 1'b1;
            end
            ST_RUN_R: begin
                if (elapsed < 5'd3)                           valve_out = 1'b1;
                else if ((elapsed >= 5'd6) && (elapsed < 5'd9)) valve_in = 1'b1;
                else                                          motor_rinse = 1'b1;
            end
            ST_RUN_S: begin
                motor_spin = 1'b1;
                if (elapsed < 5'd3) valve_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign mode    = mode_r;
    assign state   = st;
    assign t_total = tot_r;
    assign done    = (st == ST_DONE);
    assign buzz    = buzz_r;

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Directed bench for wash_seq_ctrl with default segment lengths.
module tb_wash_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       mode_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic       power_on = 1'b1;
    logic       door_closed = 1'b1;
    logic [2:0] mode;
    logic [2:0] state;
    logic [5:0] t_total;
    logic [4:0] t_seg;
    logic       valve_in, valve_out, motor_wash, motor_rinse, motor_spin;
    logic       done, buzz;

    int chk_cnt = 0;
    int pass_cnt = 0;

    wash_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .mode_btn    (mode_btn),
        .start_btn   (start_btn),
        .power_on    (power_on),
        .door_closed (door_closed),
        .mode        (mode),
        .state       (state),
        .t_total     (t_total),
        .t_seg       (t_seg),
        .valve_in    (valve_in),
        .valve_out   (valve_out),
        .motor_wash  (motor_wash),
        .motor_rinse (motor_rinse),
        .motor_spin  (motor_spin),
        .done        (done),
        .buzz        (buzz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic press_mode(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) mode_btn = 1'b1;
            @(negedge clk) mode_btn = 1'b0;
        end
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        @(negedge clk) start_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        chk_cnt++; if (mode !== 3'd0) $display("FAIL rst_mode got %0d exp 0", mode); else pass_cnt++;
        chk_cnt++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else pass_cnt++;
        chk_cnt++; if (t_total !== 6'd33) $display("FAIL rst_total got %0d exp 33", t_total); else pass_cnt++;
        chk_cnt++; if (t_seg !== 5'd0) $display("FAIL rst_seg got %0d exp 0", t_seg); else pass_cnt++;
        chk_cnt++; if ({valve_in, valve_out, motor_wash, motor_rinse, motor_spin, done, buzz} !== 7'b0)
            $display("FAIL rst_outs got %b exp 0", {valve_in, valve_out, motor_wash, motor_rinse, motor_spin, done, buzz}); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode_cycle();
        press_mode(2);
        chk_cnt++; if (mode !== 3'd2) $display("FAIL mode2 got %0d exp 2", mode); else pass_cnt++;
        chk_cnt++; if (t_total !== 6'd27) $display("FAIL mode2_total got %0d exp 27", t_total); else pass_cnt++;
        press_mode(4);
        chk_cnt++; if (mode !== 3'd0) $display("FAIL mode_wrap got %0d exp 0", mode); else pass_cnt++;
        chk_cnt++; if (t_total !== 6'd33) $display("FAIL mode_wrap_total got %0d exp 33", t_total); else pass_cnt++;
    endtask

    task automatic test_mode0_run();
        logic exp_b;
        press_start();
        chk_cnt++; if (state !== 3'd1 || t_seg !== 5'd12) $display("FAIL m0_start got st=%0d seg=%0d exp st=1 seg=12", state, t_seg); else pass_cnt++;
        chk_cnt++; if (valve_in !== 1'b1 || motor_wash !== 1'b0) $display("FAIL m0_fill0 got vi=%b mw=%b exp vi=1 mw=0", valve_in, motor_wash); else pass_cnt++;
        do_ticks(2);
        chk_cnt++; if (valve_in !== 1'b1 || t_seg !== 5'd10) $display("FAIL m0_fill2 got vi=%b seg=%0d exp vi=1 seg=10", valve_in, t_seg); else pass_cnt++;
        do_ticks(1);
        chk_cnt++; if (valve_in !== 1'b0 || motor_wash !== 1'b1 || t_total !== 6'd30)
            $display("FAIL m0_wash got vi=%b mw=%b tot=%0d exp vi=0 mw=1 tot=30", valve_in, motor_wash, t_total); else pass_cnt++;
        do_ticks(9);
        chk_cnt++; if (state !== 3'd2 || t_seg !== 5'd15 || t_total !== 6'd21)
            $display("FAIL m0_rinse got st=%0d seg=%0d tot=%0d exp st=2 seg=15 tot=21", state, t_seg, t_total); else pass_cnt++;
        chk_cnt++; if (valve_out !== 1'b1 || motor_rinse !== 1'b0) $display("FAIL m0_drain got vo=%b mr=%b exp vo=1 mr=0", valve_out, motor_rinse); else pass_cnt++;
        do_ticks(3);
        chk_cnt++; if (valve_out !== 1'b0 || motor_rinse !== 1'b1) $display("FAIL m0_r3 got vo=%b mr=%b exp vo=0 mr=1", valve_out, motor_rinse); else pass_cnt++;
        do_ticks(3);
        chk_cnt++; if (valve_in !== 1'b1 || motor_rinse !== 1'b0) $display("FAIL m0_r6 got vi=%b mr=%b exp vi=1 mr=0", valve_in, motor_rinse); else pass_cnt++;
        do_ticks(3);
        chk_cnt++; if (valve_in !== 1'b0 || motor_rinse !== 1'b1) $display("FAIL m0_r9 got vi=%b mr=%b exp vi=0 mr=1", valve_in, motor_rinse); else pass_cnt++;
        do_ticks(6);
        chk_cnt++; if (state !== 3'd3 || t_seg !== 5'd6 || t_total !== 6'd6)
            $display("FAIL m0_spin got st=%0d seg=%0d tot=%0d exp st=3 seg=6 tot=6", state, t_seg, t_total); else pass_cnt++;
        chk_cnt++; if (valve_out !== 1'b1 || motor_spin !== 1'b1) $display("FAIL m0_s0 got vo=%b ms=%b exp vo=1 ms=1", valve_out, motor_spin); else pass_cnt++;
        do_ticks(3);
        chk_cnt++; if (valve_out !== 1'b0 || motor_spin !== 1'b1) $display("FAIL m0_s3 got vo=%b ms=%b exp vo=0 ms=1", valve_out, motor_spin); else pass_cnt++;
        do_ticks(2);
        chk_cnt++; if (state !== 3'd3 || t_seg !== 5'd1 || t_total !== 6'd1)
            $display("FAIL m0_last got st=%0d seg=%0d tot=%0d exp st=3 seg=1 tot=1", state, t_seg, t_total); else pass_cnt++;
        do_ticks(1);
        chk_cnt++; if (state !== 3'd5 || t_total !== 6'd0 || t_seg !== 5'd0 || done !== 1'b1 || buzz !== 1'b1)
            $display("FAIL m0_done got st=%0d tot=%0d seg=%0d done=%b buzz=%b exp 5 0 0 1 1", state, t_total, t_seg, done, buzz); else pass_cnt++;
        chk_cnt++; if ({valve_in, valve_out, motor_wash, motor_rinse, motor_spin} !== 5'b0)
            $display("FAIL m0_done_act got %b exp 0", {valve_in, valve_out, motor_wash, motor_rinse, motor_spin}); else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            do_ticks(1);
            exp_b = (k < 8) ? ((k % 2) == 0) : 1'b0;
            chk_cnt++; if (buzz !== exp_b) $display("FAIL m0_buzz%0d got %b exp %b", k, buzz, exp_b); else pass_cnt++;
        end
        do_ticks(3);
        chk_cnt++; if (buzz !== 1'b0 || done !== 1'b1 || t_total !== 6'd0)
            $display("FAIL m0_quiet got buzz=%b done=%b tot=%0d exp 0 1 0", buzz, done, t_total); else pass_cnt++;
    endtask

    task automatic test_mode1_pause();
        press_mode(1);
        chk_cnt++; if (mode !== 3'd1 || t_total !== 6'd12 || state !== 3'd0 || done !== 1'b0)
            $display("FAIL m1_sel got mode=%0d tot=%0d st=%0d done=%b exp 1 12 0 0", mode, t_total, state, done); else pass_cnt++;
        press_start();
        do_ticks(5);
        chk_cnt++; if (t_total !== 6'd7) $display("FAIL m1_run got tot=%0d exp 7", t_total); else pass_cnt++;
        press_start();
        chk_cnt++; if (state !== 3'd4 || motor_wash !== 1'b0) $display("FAIL m1_pause got st=%0d mw=%b exp 4 0", state, motor_wash); else pass_cnt++;
        do_ticks(5);
        press_mode(1);
        chk_cnt++; if (t_total !== 6'd7 || t_seg !== 5'd7 || mode !== 3'd1)
            $display("FAIL m1_hold got tot=%0d seg=%0d mode=%0d exp 7 7 1", t_total, t_seg, mode); else pass_cnt++;
        press_start();
        chk_cnt++; if (state !== 3'd1 || t_total !== 6'd7 || motor_wash !== 1'b1)
            $display("FAIL m1_resume got st=%0d tot=%0d mw=%b exp 1 7 1", state, t_total, motor_wash); else pass_cnt++;
        do_ticks(6);
        chk_cnt++; if (state !== 3'd1 || t_total !== 6'd1) $display("FAIL m1_pre got st=%0d tot=%0d exp 1 1", state, t_total); else pass_cnt++;
        do_ticks(1);
        chk_cnt++; if (state !== 3'd5 || t_total !== 6'd0) $display("FAIL m1_done got st=%0d tot=%0d exp 5 0", state, t_total); else pass_cnt++;
    endtask

    task automatic test_mode3_door();
        press_mode(2);
        chk_cnt++; if (mode !== 3'd3 || t_total !== 6'd15) $display("FAIL m3_sel got mode=%0d tot=%0d exp 3 15", mode, t_total); else pass_cnt++;
        press_start();
        chk_cnt++; if (state !== 3'd2 || t_seg !== 5'd15) $display("FAIL m3_start got st=%0d seg=%0d exp 2 15", state, t_seg); else pass_cnt++;
        do_ticks(5);
        door_closed = 1'b0;
        step();
        chk_cnt++; if (state !== 3'd4 || t_seg !== 5'd10) $display("FAIL m3_open got st=%0d seg=%0d exp 4 10", state, t_seg); else pass_cnt++;
        chk_cnt++; if ({valve_in, valve_out, motor_wash, motor_rinse, motor_spin} !== 5'b0)
            $display("FAIL m3_open_act got %b exp 0", {valve_in, valve_out, motor_wash, motor_rinse, motor_spin}); else pass_cnt++;
        press_start();
        chk_cnt++; if (state !== 3'd4) $display("FAIL m3_open_start got st=%0d exp 4", state); else pass_cnt++;
        door_closed = 1'b1;
        press_start();
        chk_cnt++; if (state !== 3'd2 || t_seg !== 5'd10 || t_total !== 6'd10)
            $display("FAIL m3_resume got st=%0d seg=%0d tot=%0d exp 2 10 10", state, t_seg, t_total); else pass_cnt++;
        power_on = 1'b0;
        step();
        power_on = 1'b1;
        chk_cnt++; if (state !== 3'd0 || t_total !== 6'd15 || mode !== 3'd3 || t_seg !== 5'd0)
            $display("FAIL m3_poff got st=%0d tot=%0d mode=%0d seg=%0d exp 0 15 3 0", state, t_total, mode, t_seg); else pass_cnt++;
    endtask

    task automatic test_mode4_power();
        press_mode(1);
        press_start();
        chk_cnt++; if (mode !== 3'd4 || state !== 3'd2 || t_total !== 6'd21)
            $display("FAIL m4_start got mode=%0d st=%0d tot=%0d exp 4 2 21", mode, state, t_total); else pass_cnt++;
        do_ticks(3);
        @(negedge clk) begin tick = 1'b1; start_btn = 1'b1; end
        @(negedge clk) begin tick = 1'b0; start_btn = 1'b0; end
        chk_cnt++; if (state !== 3'd4 || t_seg !== 5'd12 || t_total !== 6'd18)
            $display("FAIL m4_coinc got st=%0d seg=%0d tot=%0d exp 4 12 18", state, t_seg, t_total); else pass_cnt++;
        press_start();
        do_ticks(14);
        chk_cnt++; if (state !== 3'd3 || t_seg !== 5'd4 || t_total !== 6'd4)
            $display("FAIL m4_spin got st=%0d seg=%0d tot=%0d exp 3 4 4", state, t_seg, t_total); else pass_cnt++;
        power_on = 1'b0;
        step();
        power_on = 1'b1;
        chk_cnt++; if (state !== 3'd0 || t_total !== 6'd21 || mode !== 3'd4 || t_seg !== 5'd0 || motor_spin !== 1'b0)
            $display("FAIL m4_poff got st=%0d tot=%0d mode=%0d seg=%0d ms=%b exp 0 21 4 0 0", state, t_total, mode, t_seg, motor_spin); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        press_mode(3);
        press_start();
        do_ticks(4);
        chk_cnt++; if (mode !== 3'd1 || state !== 3'd1 || motor_wash !== 1'b1)
            $display("FAIL ar_pre got mode=%0d st=%0d mw=%b exp 1 1 1", mode, state, motor_wash); else pass_cnt++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++; if (mode !== 3'd0 || state !== 3'd0 || t_total !== 6'd33 || t_seg !== 5'd0)
            $display("FAIL ar_regs got mode=%0d st=%0d tot=%0d seg=%0d exp 0 0 33 0", mode, state, t_total, t_seg); else pass_cnt++;
        chk_cnt++; if ({valve_in, valve_out, motor_wash, motor_rinse, motor_spin, done, buzz} !== 7'b0)
            $display("FAIL ar_outs got %b exp 0", {valve_in, valve_out, motor_wash, motor_rinse, motor_spin, done, buzz}); else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_mode0_run();
        test_mode1_pause();
        test_mode3_door();
        test_mode4_power();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
